// File: rtl/conv_input_loader_pkg.sv
// conv_pkg: shared types and constants for the convolution input loader.
//
// Contents:
//   state_t  - loader FSM state (START, LOAD_W, LOAD_X, WAIT)
//   addr_w() - address width for a memory of n entries (never below 1 bit)
//   DEF_*    - default problem geometry and the address widths it implies
package conv_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        LOAD_W = 2'd1,
        LOAD_X = 2'd2,
        WAIT   = 2'd3
    } state_t;

    // A one-entry memory still needs a 1-bit address port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_INW  = 12;
    localparam int DEF_R    = 9;
    localparam int DEF_C    = 8;
    localparam int DEF_K    = 4;
    localparam int DEF_X_AW = addr_w(DEF_R * DEF_C);
    localparam int DEF_W_AW = addr_w(DEF_K * DEF_K);

endpackage

// File: rtl/conv_input_loader_mem.sv
// conv_mem: single-write-port, single-read-port synchronous RAM.
// Read data is registered: the address presented at edge n is reflected
// on rdata after edge n. No reset; contents persist across loader resets.
//
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - registered read data
module conv_mem
    import conv_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int SIZE  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [addr_w(SIZE)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [addr_w(SIZE)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/conv_input_loader.sv
// conv_input_loader: AXI-Stream receiver that fills the kernel (W) and
// image (X) memories for the convolution datapath, holds the stream off
// while the datapath works, and re-opens it on compute_finished.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   INPUT_TDATA       - stream element, stored unmodified
//   INPUT_TVALID      - stream valid
//   INPUT_TUSER       - new-W flag, only looked at on a problem's first transfer
//   INPUT_TREADY      - loader can accept a transfer (decoded from state)
//   inputs_loaded     - W and X resident, read ports valid (decoded from state)
//   compute_finished  - one-cycle pulse from the datapath, honoured only in WAIT
//   X_read_addr/X_data - X memory read port, 1-cycle latency, row-major
//   W_read_addr/W_data - W memory read port, 1-cycle latency, row-major
//   fsm_state         - current FSM state, for observation
//
// Handshake: a transfer happens on a rising edge where INPUT_TVALID and
// INPUT_TREADY are both 1; INPUT_TREADY never depends on INPUT_TVALID.
module conv_input_loader
    import conv_pkg::*;
#(
    parameter int INW = DEF_INW,
    parameter int R   = DEF_R,
    parameter int C   = DEF_C,
    parameter int K   = DEF_K
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INW-1:0]          INPUT_TDATA,
    input  logic                    INPUT_TVALID,
    input  logic                    INPUT_TUSER,
    output logic                    INPUT_TREADY,
    output logic                    inputs_loaded,
    input  logic                    compute_finished,
    input  logic [addr_w(R*C)-1:0] X_read_addr,
    output logic [INW-1:0]          X_data,
    input  logic [addr_w(K*K)-1:0] W_read_addr,
    output logic [INW-1:0]          W_data,
    output state_t                  fsm_state
);

    localparam int XN  = R * C;
    localparam int WN  = K * K;
    localparam int XAW = addr_w(XN);
    localparam int WAW = addr_w(WN);
    // One counter serves both phases, so it is sized for the larger memory.
    localparam int CW  = (XAW > WAW) ? XAW : WAW;

    localparam logic [CW-1:0] W_LAST = CW'(WN - 1);
    localparam logic [CW-1:0] X_LAST = CW'(XN - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [CW-1:0]   wr_addr;
    logic            xfer;
    logic            w_we, x_we;

    assign INPUT_TREADY  = (state != WAIT);
    assign inputs_loaded = (state == WAIT);
    assign fsm_state     = state;
    assign xfer          = INPUT_TVALID & INPUT_TREADY;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_addr   = count;
        w_we      = 1'b0;
        x_we      = 1'b0;
        case (state)
            START: begin
                // First element of a problem always lands at index 0.
                wr_addr = '0;
                if (xfer) begin
                    if (INPUT_TUSER) begin
                        w_we = 1'b1;
                        if (WN == 1) begin
                            state_nxt = LOAD_X;
                            count_nxt = '0;
                        end else begin
                            state_nxt = LOAD_W;
                            count_nxt = CW'(1);
                        end
                    end else begin
                        // W is reused from the previous problem.
                        x_we = 1'b1;
                        if (XN == 1) begin
                            state_nxt = WAIT;
                            count_nxt = '0;
                        end else begin
                            state_nxt = LOAD_X;
                            count_nxt = CW'(1);
                        end
                    end
                end
            end
            LOAD_W: begin
                if (xfer) begin
                    w_we = 1'b1;
                    if (count == W_LAST) begin
                        state_nxt = LOAD_X;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            end
            LOAD_X: begin
                if (xfer) begin
                    x_we = 1'b1;
                    if (count == X_LAST) begin
                        state_nxt = WAIT;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            end
            WAIT: begin
                if (compute_finished) begin
                    state_nxt = START;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = START;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= START;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    conv_mem #(
        .WIDTH (INW),
        .SIZE  (XN)
    ) u_x_mem (
        .clk   (clk),
        .we    (x_we),
        .waddr (wr_addr[XAW-1:0]),
        .wdata (INPUT_TDATA),
        .raddr (X_read_addr),
        .rdata (X_data)
    );

    conv_mem #(
        .WIDTH (INW),
        .SIZE  (WN)
    ) u_w_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (wr_addr[WAW-1:0]),
        .wdata (INPUT_TDATA),
        .raddr (W_read_addr),
        .rdata (W_data)
    );

endmodule
